// File: rtl/dp_align_pkg.sv
// Shared types and constants for the dp_align systolic array: symbol codes, scores, boundary record.
// Latency: none (declarations only).
// Backpressure: none.
package dp_align_pkg;
  localparam int BP_WIDTH    = 2;
  localparam int CALC_WIDTH  = 10;
  localparam int N           = 4;
  localparam int SEQ_MAX_LEN = 64;

  localparam int MATCH    = 2;
  localparam int MISMATCH = 4;
  localparam int O1       = 4;
  localparam int E1       = 2;
  localparam int O2       = 24;
  localparam int E2       = 1;

  localparam int CNT_W = $clog2(SEQ_MAX_LEN);
  localparam int ROW_W = $clog2(SEQ_MAX_LEN + N);
  localparam int DRN_W = $clog2(N + 2);

  typedef enum logic [1:0] {BP_A = 2'b00, BP_C = 2'b01, BP_G = 2'b10, BP_T = 2'b11} bp_e;
  typedef enum logic [1:0] {DIR_ZERO = 2'b00, DIR_DIAG = 2'b01, DIR_E = 2'b10, DIR_F = 2'b11} dir_e;

  typedef struct packed {
    logic [CALC_WIDTH-1:0] h;
    logic [CALC_WIDTH-1:0] f1;
    logic [CALC_WIDTH-1:0] f2;
  } bnd_t;

  typedef logic [CNT_W:0] tcnt_t;

  // Two spare bits keep score arithmetic signed and overflow-free before clamping.
  localparam int SW = CALC_WIDTH + 2;
  typedef logic signed [SW-1:0] sc_t;

  localparam sc_t SC_MATCH    = sc_t'(MATCH);
  localparam sc_t SC_MISMATCH = sc_t'(MISMATCH);
  localparam sc_t SC_GO1      = sc_t'(O1 + E1);
  localparam sc_t SC_GE1      = sc_t'(E1);
  localparam sc_t SC_GO2      = sc_t'(O2 + E2);
  localparam sc_t SC_GE2      = sc_t'(E2);
  localparam sc_t SC_HMAX     = sc_t'((1 << CALC_WIDTH) - 1);

  function automatic sc_t ext(input logic [CALC_WIDTH-1:0] v);
    return sc_t'({2'b00, v});
  endfunction

  function automatic sc_t smax(input sc_t a, input sc_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic sc_t floor0(input sc_t v);
    return (v < 0) ? '0 : v;
  endfunction
endpackage

// File: rtl/dp_align_pe.sv
// One Smith-Waterman cell with two-piece affine gaps; holds one query symbol.
// Latency: 1 cycle from input column to registered H/F outputs.
// Backpressure: en=0 freezes every register; clr restarts the column walk.
module dp_align_pe
  import dp_align_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  q_ld,
  input  logic [BP_WIDTH-1:0]   q_in,
  input  logic                  in_v,
  input  logic [BP_WIDTH-1:0]   in_t,
  input  logic [CALC_WIDTH-1:0] in_h,
  input  logic [CALC_WIDTH-1:0] in_f1,
  input  logic [CALC_WIDTH-1:0] in_f2,
  output logic                  out_v,
  output logic [BP_WIDTH-1:0]   out_t,
  output logic [CALC_WIDTH-1:0] out_h,
  output logic [CALC_WIDTH-1:0] out_f1,
  output logic [CALC_WIDTH-1:0] out_f2,
  output logic [1:0]            k0,
  output logic [1:0]            k1
);
  logic [BP_WIDTH-1:0]   q;
  logic [CALC_WIDTH-1:0] diag, e1, e2;
  sc_t e1_o, e1_x, e2_o, e2_x, f1_o, f1_x, f2_o, f2_x;
  sc_t e1_n, e2_n, f1_n, f2_n, dg, gap_e, gap_f, h_raw;
  logic [CALC_WIDTH-1:0] h_n;
  dir_e dir_n;
  logic ext_e, ext_f;

  always_comb begin
    e1_o  = ext(out_h) - SC_GO1;
    e1_x  = ext(e1) - SC_GE1;
    e2_o  = ext(out_h) - SC_GO2;
    e2_x  = ext(e2) - SC_GE2;
    f1_o  = ext(in_h) - SC_GO1;
    f1_x  = ext(in_f1) - SC_GE1;
    f2_o  = ext(in_h) - SC_GO2;
    f2_x  = ext(in_f2) - SC_GE2;
    e1_n  = floor0(smax(e1_o, e1_x));
    e2_n  = floor0(smax(e2_o, e2_x));
    f1_n  = floor0(smax(f1_o, f1_x));
    f2_n  = floor0(smax(f2_o, f2_x));
    dg    = (q == in_t) ? ext(diag) + SC_MATCH : ext(diag) - SC_MISMATCH;
    gap_e = smax(e1_n, e2_n);
    gap_f = smax(f1_n, f2_n);
    h_raw = floor0(smax(dg, smax(gap_e, gap_f)));
    h_n   = (h_raw > SC_HMAX) ? '1 : h_raw[CALC_WIDTH-1:0];
    // Priority on ties: diagonal, then horizontal gap, then vertical gap.
    if (h_raw == 0)          dir_n = DIR_ZERO;
    else if (h_raw == dg)    dir_n = DIR_DIAG;
    else if (h_raw == gap_e) dir_n = DIR_E;
    else                     dir_n = DIR_F;
    ext_e = (e1_n >= e2_n) ? (e1_x > e1_o) : (e2_x > e2_o);
    ext_f = (f1_n >= f2_n) ? (f1_x > f1_o) : (f2_x > f2_o);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      q      <= '0;
      diag   <= '0;
      e1     <= '0;
      e2     <= '0;
      out_v  <= 1'b0;
      out_t  <= '0;
      out_h  <= '0;
      out_f1 <= '0;
      out_f2 <= '0;
      k0     <= '0;
      k1     <= '0;
    end else begin
      if (q_ld) q <= q_in;
      if (clr) begin
        diag   <= '0;
        e1     <= '0;
        e2     <= '0;
        out_v  <= 1'b0;
        out_t  <= '0;
        out_h  <= '0;
        out_f1 <= '0;
        out_f2 <= '0;
        k0     <= '0;
        k1     <= '0;
      end else if (en) begin
        out_v <= in_v;
        out_t <= in_t;
        if (in_v) begin
          out_h  <= h_n;
          out_f1 <= f1_n[CALC_WIDTH-1:0];
          out_f2 <= f2_n[CALC_WIDTH-1:0];
          e1     <= e1_n[CALC_WIDTH-1:0];
          e2     <= e2_n[CALC_WIDTH-1:0];
          diag   <= in_h;
          k0     <= dir_n;
          k1     <= {ext_e, ext_f};
        end
      end
    end
  end
endmodule

// File: rtl/dp_align_array.sv
// Linear systolic array scoring query S against streamed target T; blocks of N query symbols chained via a row buffer.
// Latency: busy drops N+1 cycles after the last valid T symbol; max_o is final by then.
// Backpressure: none by default; with TRACEBACK_EN, tb_busy=1 freezes the whole array.
module dp_align_array
  import dp_align_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [BP_WIDTH-1:0]   S,
  input  logic [BP_WIDTH-1:0]   T,
  input  logic                  s_update,
  input  logic                  ack,
  input  logic                  valid,
  input  logic                  new_seq,
  output logic [CALC_WIDTH-1:0] max_o,
  output logic                  busy,
  output logic                  tb_valid,
  output logic [CNT_W-1:0]      array_num,
  input  logic                  tb_busy,
  output logic [7:0]            mem_block_num,
  output logic [ROW_W-1:0]      row_num,
  output logic [2*N-1:0]        row_k0,
  output logic [2*N-1:0]        row_k1
);
  localparam tcnt_t            T_LIM = tcnt_t'(SEQ_MAX_LEN);
  localparam logic [DRN_W-1:0] DRAIN = DRN_W'(N + 1);

  logic [N-1:0][BP_WIDTH-1:0]   sreg;
  logic [N:0]                   st_v;
  logic [N:0][BP_WIDTH-1:0]     st_t;
  logic [N:0][CALC_WIDTH-1:0]   st_h, st_f1, st_f2;
  logic [N-1:0][1:0]            pe_k0, pe_k1;
  logic                         stall, sup_acc, accept, clr, wr_en;
  tcnt_t                        t_cnt, wr_cnt;
  logic [DRN_W-1:0]             drain;
  logic [ROW_W-1:0]             row_cnt;
  logic                         rb_valid, rb_use;
  logic [CALC_WIDTH-1:0]        max_q, max_n;
  bnd_t                         row_buf [SEQ_MAX_LEN];
  bnd_t                         bnd;

`ifdef TRACEBACK_EN
  assign stall = tb_busy;
`else
  assign stall = 1'b0;
`endif

  assign busy    = (drain != '0);
  assign sup_acc = s_update && !busy && !new_seq;
  assign accept  = valid && !stall && !new_seq && !sup_acc && (t_cnt < T_LIM);
  assign clr     = new_seq || sup_acc;
  assign wr_en   = !stall && !new_seq && st_v[N] && (wr_cnt < T_LIM);
  assign max_o   = max_q;

  // Block 0 sees an all-zero boundary row; later blocks read what PE N-1 left behind.
  assign bnd      = rb_use ? row_buf[t_cnt[CNT_W-1:0]] : '0;
  assign st_v[0]  = accept;
  assign st_t[0]  = T;
  assign st_h[0]  = bnd.h;
  assign st_f1[0] = bnd.f1;
  assign st_f2[0] = bnd.f2;

  for (genvar k = 0; k < N; k++) begin : g_pe
    dp_align_pe u_pe (
      .clk     (clk),
      .reset_i (reset_i),
      .clr     (clr),
      .en      (!stall),
      .q_ld    (sup_acc),
      .q_in    (sreg[k]),
      .in_v    (st_v[k]),
      .in_t    (st_t[k]),
      .in_h    (st_h[k]),
      .in_f1   (st_f1[k]),
      .in_f2   (st_f2[k]),
      .out_v   (st_v[k+1]),
      .out_t   (st_t[k+1]),
      .out_h   (st_h[k+1]),
      .out_f1  (st_f1[k+1]),
      .out_f2  (st_f2[k+1]),
      .k0      (pe_k0[k]),
      .k1      (pe_k1[k])
    );
  end

  always_comb begin
    max_n = max_q;
    for (int k = 1; k <= N; k++) begin
      if (st_v[k] && (st_h[k] > max_n)) max_n = st_h[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sreg          <= '0;
      t_cnt         <= '0;
      wr_cnt        <= '0;
      drain         <= '0;
      row_cnt       <= '0;
      rb_valid      <= 1'b0;
      rb_use        <= 1'b0;
      mem_block_num <= '0;
      max_q         <= '0;
    end else begin
      if (ack && !s_update) sreg <= {sreg[N-2:0], S};
      if (new_seq) begin
        t_cnt         <= '0;
        wr_cnt        <= '0;
        drain         <= '0;
        row_cnt       <= '0;
        rb_valid      <= 1'b0;
        rb_use        <= 1'b0;
        mem_block_num <= '0;
        max_q         <= '0;
      end else begin
        if (sup_acc) begin
          t_cnt   <= '0;
          wr_cnt  <= '0;
          row_cnt <= '0;
          rb_use  <= rb_valid;
          if (rb_valid) mem_block_num <= mem_block_num + 8'd1;
        end else if (!stall) begin
          if (accept) t_cnt <= t_cnt + tcnt_t'(1);
          if (wr_en) begin
            wr_cnt   <= wr_cnt + tcnt_t'(1);
            rb_valid <= 1'b1;
          end
          if (busy) row_cnt <= row_cnt + ROW_W'(1);
        end
        if (!stall) begin
          if (accept)              drain <= DRAIN;
          else if (drain != '0)    drain <= drain - DRN_W'(1);
        end
        max_q <= max_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) row_buf[wr_cnt[CNT_W-1:0]] <= '{h: st_h[N], f1: st_f1[N], f2: st_f2[N]};
  end

`ifdef TRACEBACK_EN
  assign tb_valid  = |st_v[N:1];
  assign array_num = CNT_W'(t_cnt - tcnt_t'(1));
  assign row_num   = row_cnt;
  assign row_k0    = pe_k0;
  assign row_k1    = pe_k1;
`else
  logic unused_tb;
  assign unused_tb = ^{tb_busy, pe_k0, pe_k1, row_cnt};
  assign tb_valid  = 1'b0;
  assign array_num = '0;
  assign row_num   = '0;
  assign row_k0    = '0;
  assign row_k1    = '0;
`endif

  logic unused_tail;
  assign unused_tail = ^st_t[N];
endmodule

// File: tb/tb_dp_align_array.sv
// Directed bench for dp_align_array: table of query/target pairs plus abort, reset and length-limit sequences.
module tb_dp_align_array;
  import dp_align_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_i, s_update, ack, valid, new_seq, tb_busy;
  logic [BP_WIDTH-1:0]   S, T;
  logic [CALC_WIDTH-1:0] max_o;
  logic                  busy, tb_valid;
  logic [CNT_W-1:0]      array_num;
  logic [7:0]            mem_block_num;
  logic [ROW_W-1:0]      row_num;
  logic [2*N-1:0]        row_k0, row_k1;

  always #5 clk = ~clk;

  dp_align_array dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .S             (S),
    .T             (T),
    .s_update      (s_update),
    .ack           (ack),
    .valid         (valid),
    .new_seq       (new_seq),
    .max_o         (max_o),
    .busy          (busy),
    .tb_valid      (tb_valid),
    .array_num     (array_num),
    .tb_busy       (tb_busy),
    .mem_block_num (mem_block_num),
    .row_num       (row_num),
    .row_k0        (row_k0),
    .row_k1        (row_k1)
  );

  typedef struct {
    logic [17:0] q;
    int          qlen;
    logic [17:0] t;
    int          tlen;
    int          exp_max;
    int          exp_blk;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  tseq [128];
  vec_t        vecs [6];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic [17:0] enc(input string s);
    logic [17:0] r = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "C":     r[2*i +: 2] = 2'd1;
        "G":     r[2*i +: 2] = 2'd2;
        "T":     r[2*i +: 2] = 2'd3;
        default: r[2*i +: 2] = 2'd0;
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_seq();
    new_seq = 1'b1;
    step();
    new_seq = 1'b0;
  endtask

  task automatic load_block(input logic [17:0] q, input int b);
    for (int i = N - 1; i >= 0; i--) begin
      S   = q[2*(b*N+i) +: 2];
      ack = 1'b1;
      step();
    end
    ack = 1'b0;
    s_update = 1'b1;
    step();
    s_update = 1'b0;
  endtask

  task automatic stream(input int len, input string tag);
    valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      T = tseq[i];
      step();
      if (i == 0) check({tag, "_busy_rise"}, int'(busy), 1);
    end
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic run_pair(input vec_t v, input int id);
    int lat;
    string tag;
    tag = $sformatf("v%0d", id);
    pulse_new_seq();
    for (int b = 0; b < v.qlen / N; b++) begin
      load_block(v.q, b);
      for (int i = 0; i < v.tlen; i++) tseq[i] = v.t[2*i +: 2];
      stream(v.tlen, tag);
      wait_idle(lat);
      check($sformatf("%s_b%0d_busy_lat", tag, b), lat, N + 1);
    end
    check({tag, "_max"}, int'(max_o), v.exp_max);
    check({tag, "_blk"}, int'(mem_block_num), v.exp_blk);
  endtask

  initial begin
    int lat;
    reset_i = 1'b1; s_update = 1'b0; ack = 1'b0; valid = 1'b0;
    new_seq = 1'b0; tb_busy = 1'b0; S = '0; T = '0;
    step();
    step();
    reset_i = 1'b0;
    step();
    check("rst_max", int'(max_o), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_blk", int'(mem_block_num), 0);
    check("rst_tb_valid", int'(tb_valid), 0);
    check("rst_row_k0", int'(row_k0), 0);

    vecs[0] = '{enc("ACGT"), 4, enc("ACGT"), 4, 8, 0};
    vecs[1] = '{enc("AAAA"), 4, enc("CCCC"), 4, 0, 0};
    vecs[2] = '{enc("AAAAAAAA"), 8, enc("AAAAGAAAA"), 9, 10, 1};
    vecs[3] = '{enc("AAAAAAAA"), 8, enc("AAAAAAAA"), 8, 16, 1};
    vecs[4] = '{enc("AAAA"), 4, enc("GGGG"), 4, 0, 0};
    vecs[5] = '{enc("CCCC"), 4, enc("ACCCCG"), 6, 8, 0};
    for (int v = 0; v < 6; v++) run_pair(vecs[v], v);

    // s_update during a block must not restart it or bump the block index
    pulse_new_seq();
    load_block(enc("AAAA"), 0);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      T = 2'd0;
      s_update = (i == 2);
      step();
    end
    valid = 1'b0; s_update = 1'b0;
    wait_idle(lat);
    check("supd_busy_max", int'(max_o), 8);
    check("supd_busy_blk", int'(mem_block_num), 0);

    // new_seq mid-block aborts immediately
    pulse_new_seq();
    load_block(enc("AAAA"), 0);
    valid = 1'b1; T = 2'd0;
    step();
    step();
    valid = 1'b0;
    check("abort_pre_max", int'(max_o), 2);
    new_seq = 1'b1;
    step();
    new_seq = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_max", int'(max_o), 0);

    // Only the first SEQ_MAX_LEN target symbols count
    pulse_new_seq();
    load_block(enc("AAAA"), 0);
    for (int i = 0; i < 70; i++) tseq[i] = (i < SEQ_MAX_LEN - 1) ? 2'd1 : 2'd0;
    stream(70, "maxlen");
    wait_idle(lat);
    check("maxlen_busy", int'(busy), 0);
    check("maxlen_max", int'(max_o), 2);

    // Reset mid-stream, then a clean pair
    pulse_new_seq();
    load_block(enc("AAAA"), 0);
    valid = 1'b1; T = 2'd0;
    step();
    step();
    step();
    valid = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_max", int'(max_o), 0);
    run_pair(vecs[0], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dp_align_array.md
Name: dp_align_array

Overview:
- Linear systolic array of N processing elements computing the local alignment score (Smith-Waterman, two-piece affine gap) between a query S and a target T, both 2-bit nucleotide sequences.
- S is loaded serially in blocks of N symbols. T is streamed one symbol per cycle.
- Queries longer than N are processed as successive blocks, with the boundary column kept in an internal row buffer.
- Reports the best score of the pair on max_o.

Parameters:
- BP_WIDTH, 2: symbol width. Encoding A=00, C=01, G=10, T=11.
- CALC_WIDTH, 10: unsigned score width; H saturates at 2^CALC_WIDTH-1.
- N, 4: number of PEs (query symbols per block).
- SEQ_MAX_LEN, 64: maximum T length; depth of the row buffer.
- MATCH 2, MISMATCH 4, O1 4, E1 2, O2 24, E2 1: scoring constants (all positive magnitudes).

Ports:
- clk, in, 1: clock, rising edge.
- reset_i, in, 1: synchronous active-high reset.
- S, in, BP_WIDTH: query symbol serial input.
- T, in, BP_WIDTH: target symbol stream.
- s_update, in, 1: latch the query shift register into the PEs.
- ack, in, 1: shift-enable for S.
- valid, in, 1: T symbol valid.
- new_seq, in, 1: start a new sequence pair.
- max_o, out, CALC_WIDTH: best score of the current pair.
- busy, out, 1: array computing.
- tb_valid, out, 1: traceback row valid.
- array_num, out, clog2(SEQ_MAX_LEN): T column index of the traceback row.
- tb_busy, in, 1: traceback consumer busy.
- mem_block_num, out, 8: current query block index.
- row_num, out, clog2(SEQ_MAX_LEN+N): cycle within the block.
- row_k0, out, 2N: per-PE H-source codes.
- row_k1, out, 2N: per-PE gap-extension flags.

Behaviour:
- Reset: all outputs 0. Shift register, PEs, row buffer valid flag, block counter and max all cleared.
- new_seq (1 cycle): clears max_o, block index and the row buffer valid flag.
- S loading:
  - On each edge with ack=1 and s_update=0, sreg shifts {sreg[N-2:0],S}.
  - The host sends block symbols highest index first, so PE k ends up holding query symbol j*N+k.
- s_update: copies sreg into the PEs and resets the T column counter. After the first block, it also increments mem_block_num.
- T streaming:
  - A T symbol enters PE0 on each edge with valid=1.
  - Symbols and results advance one PE per cycle.
  - T symbols are contiguous. A gap in valid ends the block.
- Recurrences, per PE k at column t, with up = PE k-1 (or the boundary for PE0):
  - E1 = max(H(k,t-1)-O1-E1, E1(k,t-1)-E1); E2 likewise with O2 and E2.
  - F1/F2: same recurrences using up values at column t.
  - H = max(0, Hup(t-1)±sub, E1, E2, F1, F2), where sub = +MATCH on equal symbols, else -MISMATCH.
  - E and F floor at 0. H saturates at the top of its range.
- Boundary at PE0:
  - Block 0 uses H=F=0.
  - Later blocks read (H,F1,F2) of column t from the row buffer, written by PE N-1 during the previous block.
- max_o: updated each cycle with the max of all PE H outputs.
- busy:
  - Rises on the edge capturing the first valid symbol.
  - Falls N+1 cycles after the last valid symbol.
  - With TRACEBACK_EN, busy is also held while tb_busy=1.
- Out-of-order inputs:
  - s_update while busy is ignored.
  - new_seq while busy aborts the block: busy falls next cycle and max is cleared.
  - T beyond SEQ_MAX_LEN is ignored.
- Reset mid-operation returns to idle immediately.

Optional Feature:
- TRACEBACK_EN defined:
  - Each computing cycle drives tb_valid=1, array_num, row_num and mem_block_num.
  - row_k0 per PE: 00 zero, 01 diagonal, 10 E, 11 F.
  - row_k1 per PE: E-extend and F-extend flags.
  - tb_busy=1 freezes the array (no advance, valid input must hold).
- TRACEBACK_EN undefined:
  - tb outputs are 0 and tb_busy is ignored.

Decomposition:
- Package dp_align_pkg: symbol encoding, score constants, CALC_WIDTH, the boundary record type (H,F1,F2) and the direction codes.
- One sub-module, dp_align_pe: a single cell containing the recurrences and registers.
- Top level holds: shift register, row buffer, counters, max tree and busy control.

Test Plan:
- N=4, S=ACGT, T=ACGT, one block -> max_o=8, busy low 5 cycles after the last valid.
- S=AAAA, T=CCCC -> max_o=0.
- S=AAAAAAAA (two blocks), T=AAAAAAAA -> max_o=16, mem_block_num reaches 1.
- S=AAAAAAAA, T=AAAAGAAAA -> max_o=10.
- After the 16-score pair, new_seq then S=AAAA, T=GGGG -> max_o=0.
- Reset asserted mid-stream -> busy=0 and max_o=0 next cycle; a following pair scores correctly.
